// File: rtl/m68k_bus_master.sv
// Round-robin 68000-style bus master: arbitrates up to four requesters onto one
// asynchronous 68K bus, with minimum wait, DTACK timeout and byte-lane masking.
module m68k_bus_master #(
  parameter int N_CH     = 2,
  parameter int MIN_WAIT = 0,
  parameter int TIMEOUT  = 32
) (
  input  logic                 CLK_68KCLK,
  input  logic                 nRESET,
  input  logic [N_CH-1:0]      REQ,
  input  logic [N_CH-1:0]      REQ_WR,
  input  logic [N_CH*23-1:0]   REQ_ADDR,
  input  logic [N_CH*2-1:0]    REQ_BE,
  input  logic [N_CH*16-1:0]   REQ_WDATA,
  output logic [N_CH-1:0]      ACK,
  output logic                 BERR,
  output logic [15:0]          RDATA,
  output logic                 BUSY,
  output logic [22:0]          M68K_ADDR,
  inout  wire  [15:0]          M68K_DATA,
  output logic                 nAS,
  output logic                 nUDS,
  output logic                 nLDS,
  output logic                 M68K_RW,
  input  logic                 nDTACK
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ASSERT, S_WAIT, S_DATA, S_END
  } state_t;

  localparam logic [1:0] LAST_CH = 2'(N_CH - 1);

  state_t      state;
  logic [1:0]  ptr;
  logic [1:0]  gnt;
  logic        wr_q;
  logic [1:0]  be_q;
  logic [15:0] wdata_q;
  logic        data_oe;
  logic        err_q;
  logic [7:0]  wait_cnt;

  // Channel fields widened to four slots so a 2-bit index is always in range.
  logic [3:0]  req_pad;
  logic [3:0]  wr_pad;
  logic [91:0] addr_pad;
  logic [7:0]  be_pad;
  logic [63:0] wdata_pad;

  assign req_pad   = 4'(REQ);
  assign wr_pad    = 4'(REQ_WR);
  assign addr_pad  = 92'(REQ_ADDR);
  assign be_pad    = 8'(REQ_BE);
  assign wdata_pad = 64'(REQ_WDATA);

  logic       sel_found;
  logic [1:0] sel;
  logic [2:0] cand;

  // First requesting channel at or after the round-robin pointer.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    sel_found = 1'b0;
    sel       = ptr;
    cand      = 3'd0;
    for (int i = 0; i < N_CH; i++) begin
      cand = 3'(ptr) + 3'(i);
      if (cand >= 3'(N_CH)) cand = cand - 3'(N_CH);
      if (!sel_found && req_pad[cand[1:0]]) begin
        sel_found = 1'b1;
        sel       = cand[1:0];
      end
    end
  end

  assign M68K_DATA = data_oe ? wdata_q : 16'bz;

  // NOTE: all state and output registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_68KCLK) begin
    if (!nRESET) begin
      state     <= S_IDLE;
      ptr       <= 2'd0;
      gnt       <= 2'd0;
      wr_q      <= 1'b0;
      be_q      <= 2'b00;
      wdata_q   <= 16'h0000;
      data_oe   <= 1'b0;
      err_q     <= 1'b0;
      wait_cnt  <= 8'd0;
      ACK       <= '0;
      BERR      <= 1'b0;
      RDATA     <= 16'h0000;
      BUSY      <= 1'b0;
      M68K_ADDR <= 23'h0;
      nAS       <= 1'b1;
      nUDS      <= 1'b1;
      nLDS      <= 1'b1;
      M68K_RW   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          ACK  <= '0;
          BERR <= 1'b0;
          if (sel_found) begin
            gnt     <= sel;
            ptr     <= (sel == LAST_CH) ? 2'd0 : sel + 2'd1;
            wr_q    <= wr_pad[sel];
            be_q    <= be_pad[int'(sel)*2 +: 2];
            wdata_q <= wdata_pad[int'(sel)*16 +: 16];
            err_q   <= 1'b0;
            BUSY    <= 1'b1;
            if (be_pad[int'(sel)*2 +: 2] == 2'b00) begin
              // Empty byte mask: acknowledge without touching the bus.
              state <= S_END;
              RDATA <= 16'h0000;
              for (int c = 0; c < N_CH; c++) ACK[c] <= (sel == 2'(c));
            end else begin
              state     <= S_ADDR;
              M68K_ADDR <= addr_pad[int'(sel)*23 +: 23];
              M68K_RW   <= ~wr_pad[sel];
              data_oe   <= wr_pad[sel];
            end
          end
        end
        S_ADDR: begin
          state <= S_ASSERT;
          nAS   <= 1'b0;
          if (!wr_q) begin
            nUDS <= ~be_q[1];
            nLDS <= ~be_q[0];
          end
        end
        S_ASSERT: begin
          state    <= S_WAIT;
          wait_cnt <= 8'd0;
          if (wr_q) begin
            nUDS <= ~be_q[1];
            nLDS <= ~be_q[0];
          end
        end
        S_WAIT: begin
          if (!nDTACK && wait_cnt >= 8'(MIN_WAIT)) begin
            state <= S_DATA;
          end else if (TIMEOUT != 0 && wait_cnt == 8'(TIMEOUT)) begin
            state <= S_END;
            err_q <= 1'b1;
            nAS   <= 1'b1;
            nUDS  <= 1'b1;
            nLDS  <= 1'b1;
            BERR  <= 1'b1;
            RDATA <= 16'h0000;
            for (int c = 0; c < N_CH; c++) ACK[c] <= (gnt == 2'(c));
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DATA: begin
          state <= S_END;
          nAS   <= 1'b1;
          nUDS  <= 1'b1;
          nLDS  <= 1'b1;
          BERR  <= 1'b0;
          if (!wr_q)
            RDATA <= {be_q[1] ? M68K_DATA[15:8] : 8'h00,
                      be_q[0] ? M68K_DATA[7:0]  : 8'h00};
          for (int c = 0; c < N_CH; c++) ACK[c] <= (gnt == 2'(c));
        end
        S_END: begin
          state   <= S_IDLE;
          ACK     <= '0;
          BERR    <= 1'b0;
          BUSY    <= 1'b0;
          M68K_RW <= 1'b1;
          data_oe <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Scoreboard bench for m68k_bus_master: directed transactions push expected
// completions; a negedge monitor pops and compares on every ACK.
module tb_m68k_bus_master;

  localparam int N_CH = 2;

  logic              clk = 1'b0;
  logic              nreset;
  logic [N_CH-1:0]   req, req_wr;
  logic [N_CH*23-1:0] req_addr;
  logic [N_CH*2-1:0] req_be;
  logic [N_CH*16-1:0] req_wdata;
  logic [N_CH-1:0]   ack;
  logic              berr, busy;
  logic [15:0]       rdata;
  logic [22:0]       m68k_addr;
  wire  [15:0]       m68k_data;
  logic              nas, nuds, nlds, m68k_rw;
  wire               ndtack;

  logic        dtack_en;
  logic [15:0] bus_val;

  // Simple slave: acknowledges while nAS is low, drives data on reads only.
  assign ndtack    = (dtack_en && !nas) ? 1'b0 : 1'b1;
  assign m68k_data = (!nas && m68k_rw) ? bus_val : 16'bz;

  m68k_bus_master #(.N_CH(N_CH), .MIN_WAIT(0), .TIMEOUT(4)) dut (
    .CLK_68KCLK(clk), .nRESET(nreset),
    .REQ(req), .REQ_WR(req_wr), .REQ_ADDR(req_addr), .REQ_BE(req_be),
    .REQ_WDATA(req_wdata), .ACK(ack), .BERR(berr), .RDATA(rdata), .BUSY(busy),
    .M68K_ADDR(m68k_addr), .M68K_DATA(m68k_data), .nAS(nas), .nUDS(nuds),
    .nLDS(nlds), .M68K_RW(m68k_rw), .nDTACK(ndtack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    logic [15:0] rdata;
    logic        berr;
    bit          chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every ACK must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack != '0) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 32'(ack), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_ack_ch", 32'(ack), 32'(1 << e.ch));
        check("sb_berr", 32'(berr), 32'(e.berr));
        if (e.chk_data) check("sb_rdata", 32'(rdata), 32'(e.rdata));
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [22:0] addr,
                         input logic [1:0] be, input logic [15:0] wdata);
    req_wr[ch]             = wr;
    req_addr[ch*23 +: 23]  = addr;
    req_be[ch*2 +: 2]      = be;
    req_wdata[ch*16 +: 16] = wdata;
    req[ch]                = 1'b1;
  endtask

  task automatic expect_ack(input int ch, input logic [15:0] d, input logic be_err, input bit chk);
    exp_t e;
    e.ch = ch; e.rdata = d; e.berr = be_err; e.chk_data = chk;
    exp_q.push_back(e);
  endtask

  initial begin
    int last, got, budget, ack_at;
    bit nas_seen;
    nreset = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_be = '0; req_wdata = '0;
    dtack_en = 1'b1; bus_val = 16'h0000;
    step(3);
    check("rst_nas", 32'({nas, nuds, nlds, m68k_rw}), 32'hF);
    check("rst_outs", 32'({ack, berr, busy}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_addr", 32'(m68k_addr), 32'd0);
    nreset = 1'b1;
    step(2);

    // Full-width read on ch0; grant cycle n is the cycle where REQ is set.
    bus_val = 16'hA55A;
    set_req(0, 1'b0, 23'h000100, 2'b11, 16'h0);
    expect_ack(0, 16'hA55A, 1'b0, 1'b1);
    step(1);
    check("rd_addr", 32'(m68k_addr), 32'h100);
    check("rd_rw_nas", 32'({m68k_rw, nas}), 32'b11);
    check("rd_busy", 32'(busy), 32'd1);
    step(1);
    check("rd_strobes_n2", 32'({nas, nuds, nlds}), 32'b000);
    step(2);
    check("rd_nas_n4", 32'(nas), 32'd0);
    step(1);
    check("rd_ack_n5", 32'(ack), 32'b01);
    check("rd_nas_n5", 32'({nas, nuds, nlds}), 32'b111);
    req = '0;
    step(1);
    check("rd_ack_clear", 32'(ack), 32'd0);
    check("rd_rdata_hold", 32'(rdata), 32'hA55A);
    step(2);

    // Lower-byte read; the upper lane carries garbage that must be masked.
    bus_val = 16'hEE3C;
    set_req(0, 1'b0, 23'h000200, 2'b01, 16'h0);
    expect_ack(0, 16'h003C, 1'b0, 1'b1);
    step(2);
    check("lb_strobes_n2", 32'({nuds, nlds}), 32'b10);
    step(2);
    check("lb_strobes_n4", 32'({nuds, nlds}), 32'b10);
    step(1);
    check("lb_ack_n5", 32'(ack), 32'b01);
    req = '0;
    step(3);

    // Upper-byte write on ch1.
    set_req(1, 1'b1, 23'h000300, 2'b10, 16'h1234);
    expect_ack(1, 16'h0, 1'b0, 1'b0);
    step(1);
    check("wr_data_n1", 32'(m68k_data), 32'h1234);
    check("wr_rw_n1", 32'(m68k_rw), 32'd0);
    step(1);
    check("wr_ds_n2", 32'({nas, nuds, nlds}), 32'b011);
    step(1);
    check("wr_ds_n3", 32'({nuds, nlds}), 32'b01);
    step(2);
    check("wr_data_n5", 32'(m68k_data), 32'h1234);
    check("wr_ack_n5", 32'(ack), 32'b10);
    req = '0;
    step(1);
    check("wr_rw_n6", 32'(m68k_rw), 32'd1);
    step(2);

    // DTACK never arrives: bus error after TIMEOUT+1 wait cycles.
    dtack_en = 1'b0;
    set_req(0, 1'b0, 23'h000400, 2'b11, 16'h0);
    expect_ack(0, 16'h0000, 1'b1, 1'b1);
    step(7);
    check("to_noack_n7", 32'({ack, nas}), 32'd0);
    step(1);
    check("to_ack_n8", 32'({ack, berr}), 32'b011);
    check("to_strobes_n8", 32'({nas, nuds, nlds}), 32'b111);
    req = '0;
    dtack_en = 1'b1;
    step(3);

    // Empty byte mask on ch1: quick ACK, no strobe activity.
    set_req(1, 1'b0, 23'h000500, 2'b00, 16'h0);
    expect_ack(1, 16'h0000, 1'b0, 1'b1);
    ack_at = 0; nas_seen = 0;
    for (int j = 1; j <= 4; j++) begin
      step(1);
      if (!nas) nas_seen = 1;
      if (ack != '0 && ack_at == 0) begin ack_at = j; req = '0; end
    end
    check("be0_ack_lat", 32'((ack_at >= 1 && ack_at <= 2) ? 1 : 0), 32'd1);
    check("be0_no_nas", 32'(nas_seen), 32'd0);
    step(2);

    // Fairness: both channels request continuously.
    bus_val = 16'h5A5A;
    set_req(0, 1'b0, 23'h000600, 2'b11, 16'h0);
    set_req(1, 1'b0, 23'h000700, 2'b11, 16'h0);
    for (int k = 0; k < 4; k++) expect_ack(k % 2, 16'h5A5A, 1'b0, 1'b1);
    last = -1; got = 0; budget = 0;
    while (got < 4 && budget < 60) begin
      step(1);
      budget++;
      if (ack != '0) begin
        if (last >= 0) check("fair_gap", 32'(cyc - last), 32'd6);
        last = cyc;
        got++;
        if (got == 4) req = '0;
      end
    end
    check("fair_done", 32'(got), 32'd4);
    step(3);

    // Reset in WAIT: no ACK, pointer back to 0.
    dtack_en = 1'b0;
    set_req(1, 1'b0, 23'h000800, 2'b11, 16'h0);
    step(4);
    nreset = 1'b0;
    step(1);
    check("rstw_strobes", 32'({nas, nuds, nlds, m68k_rw}), 32'hF);
    check("rstw_outs", 32'({ack, busy}), 32'd0);
    req = '0;
    nreset = 1'b1;
    dtack_en = 1'b1;
    step(2);
    bus_val = 16'hC3C3;
    set_req(0, 1'b0, 23'h000900, 2'b11, 16'h0);
    set_req(1, 1'b0, 23'h000A00, 2'b11, 16'h0);
    expect_ack(0, 16'hC3C3, 1'b0, 1'b1);
    step(5);
    check("rstw_ch0_wins", 32'(ack), 32'b01);
    req = '0;
    step(4);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
